// File: rtl/rv_icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// The helpers take the field widths as arguments so every user slices the same way.
package rv_icache_pkg;

  typedef enum logic {IC_IDLE, IC_REFILL} icache_state_t;

  function automatic logic [31:0] ic_offset(input logic [31:0] addr, input int line_words_bits);
    return (addr >> 2) & ((32'd1 << line_words_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] ic_index(input logic [31:0] addr, input int line_words_bits,
                                           input int sets_bits);
    return (addr >> (line_words_bits + 2)) & ((32'd1 << sets_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] ic_tag(input logic [31:0] addr, input int line_words_bits,
                                         input int sets_bits);
    return addr >> (line_words_bits + sets_bits + 2);
  endfunction

endpackage

// File: rtl/rv_icache_ram.sv
// Instruction data store: one synchronous read port, one write port.
// Only the read register is reset; array contents are undefined until refilled.
module rv_icache_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rd_en,
  input  logic [DEPTH_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data,
  input  logic                  i_wr_en,
  input  logic [DEPTH_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data
);

  logic [WIDTH-1:0] mem [1 << DEPTH_BITS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Read data holds between reads so the fetch side sees a stable word.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/rv_icache.sv
// Direct-mapped read-only instruction cache between fetch and the instruction bus.
// Hits ack combinationally; misses refill the whole line from word 0 before retrying.
module rv_icache
  import rv_icache_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int LINE_WORDS_BITS  = 2,
  parameter int SETS_BITS        = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_cyc,
  input  logic [IADDR_SPACE_BITS-1:0] i_addr,
  output logic                        o_ack,
  output logic [31:0]                 o_instruction,
  output logic                        o_mem_cyc,
  output logic [IADDR_SPACE_BITS-1:0] o_mem_addr,
  input  logic                        i_mem_ack,
  input  logic [31:0]                 i_mem_data,
  output icache_state_t               o_dbg_state
);

  localparam int TAG_BITS = IADDR_SPACE_BITS - SETS_BITS - LINE_WORDS_BITS - 2;
  localparam int SETS     = 1 << SETS_BITS;
  localparam int RAM_BITS = SETS_BITS + LINE_WORDS_BITS;

  // Memory bus handshake: o_mem_cyc/o_mem_addr are held stable until the cycle
  // i_mem_ack is high; that cycle carries i_mem_data and retires the word. One
  // request is outstanding at a time, and addresses advance only after an ack.
  icache_state_t              state;
  logic [SETS-1:0]            valid_q;
  logic [TAG_BITS-1:0]        tag_q [SETS];
  logic [TAG_BITS-1:0]        req_tag, rtag;
  logic [SETS_BITS-1:0]       req_index, rindex;
  logic [LINE_WORDS_BITS-1:0] req_offset, cnt, cnt_next;
  logic                       killed, hit, last_word, refill_ack;

  assign req_tag    = TAG_BITS'(ic_tag(32'(i_addr), LINE_WORDS_BITS, SETS_BITS));
  assign req_index  = SETS_BITS'(ic_index(32'(i_addr), LINE_WORDS_BITS, SETS_BITS));
  assign req_offset = LINE_WORDS_BITS'(ic_offset(32'(i_addr), LINE_WORDS_BITS));

  assign hit        = (state == IC_IDLE) && i_cyc && valid_q[req_index]
                      && (tag_q[req_index] == req_tag);
  assign cnt_next   = cnt + LINE_WORDS_BITS'(1);
  assign last_word  = &cnt;
  assign refill_ack = (state == IC_REFILL) && i_mem_ack;

  assign o_ack       = hit;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IC_IDLE;
      valid_q    <= '0;
      rtag       <= '0;
      rindex     <= '0;
      cnt        <= '0;
      killed     <= 1'b0;
      o_mem_cyc  <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (i_cyc && !hit) begin
            state      <= IC_REFILL;
            rtag       <= req_tag;
            rindex     <= req_index;
            cnt        <= '0;
            killed     <= 1'b0;
            o_mem_cyc  <= 1'b1;
            o_mem_addr <= {req_tag, req_index, {LINE_WORDS_BITS{1'b0}}, 2'b00};
          end
        end
        IC_REFILL: begin
          if (i_flush) killed <= 1'b1;
          if (i_mem_ack) begin
            cnt <= cnt_next;
            if (last_word) begin
              state           <= IC_IDLE;
              o_mem_cyc       <= 1'b0;
              valid_q[rindex] <= !killed;
            end else begin
              o_mem_addr <= {rtag, rindex, cnt_next, 2'b00};
            end
          end
        end
        default: state <= IC_IDLE;
      endcase
      // Placed last so a flush overrides a same-cycle line validation.
      if (i_flush) valid_q <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && refill_ack && last_word) tag_q[rindex] <= rtag;
  end

  rv_icache_ram #(
    .WIDTH     (32),
    .DEPTH_BITS(RAM_BITS)
  ) u_ram (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_rd_en  (hit),
    .i_rd_addr({req_index, req_offset}),
    .o_rd_data(o_instruction),
    .i_wr_en  (refill_ack),
    .i_wr_addr({rindex, cnt}),
    .i_wr_data(i_mem_data)
  );

endmodule
